// File: rtl/code_entry_ctrl.sv
// code_entry_ctrl: button-driven 4-digit code entry with result hold, lockout and seven-segment value output
// Optional feature macro: CODE_ENTRY_BLINK_EN (blink result/lockout value every BLINK_CYCLES)
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_inc    raw async button, increment current digit
//   btn_next   raw async button, accept digit and advance
//   btn_clear  raw async button, restart the entry
//   value      registered decoder code (0-9 digit, 10 correct, 11 error, 12 off)
//   digit_idx  index of the digit being entered, 0 outside entry
//   unlocked   high while the correct-code result is shown
//   locked     high while in failure lockout
module code_entry_ctrl #(
  parameter logic [15:0] CODE          = 16'h1234,
  parameter logic [23:0] RESULT_CYCLES = 24'd10_000_000,
  parameter logic [23:0] LOCK_CYCLES   = 24'd50_000_000,
  parameter logic [1:0]  MAX_FAIL      = 2'd3,
  parameter logic [23:0] BLINK_CYCLES  = 24'd2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_clear,
  output logic [3:0] value,
  output logic [1:0] digit_idx,
  output logic       unlocked,
  output logic       locked
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ENTRY   = 3'd1;
  localparam logic [2:0] RES_OK  = 3'd2;
  localparam logic [2:0] RES_ERR = 3'd3;
  localparam logic [2:0] LOCKOUT = 3'd4;
  if (MAX_FAIL == 2'd0 || BLINK_CYCLES == 24'd0) begin : g_bad_param
    $error("code_entry_ctrl: MAX_FAIL and BLINK_CYCLES must be nonzero");
  end
  logic [2:0] s1, s2, prev, pulse;
  logic [2:0] state, state_d;
  logic [1:0] idx, idx_d, fail_cnt, fail_d;
  logic [3:0] cur_digit, cur_d, value_d;
  logic [23:0] timer, timer_d;
  logic match, match_d, show_d;
  logic p_inc, p_next, p_clr;
  assign pulse = s2 & ~prev;
  assign p_clr = pulse[2];
  assign p_next = pulse[1] & ~p_clr;
  assign p_inc = pulse[0] & ~pulse[1] & ~p_clr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
    end else begin
      s1 <= {btn_clear, btn_next, btn_inc};
      s2 <= s1;
      prev <= s2;
    end
  end
  always_comb begin
    state_d = state;
    idx_d = idx;
    cur_d = cur_digit;
    match_d = match;
    fail_d = fail_cnt;
    timer_d = timer;
    case (state)
      IDLE: if (p_next | p_inc) begin
        state_d = ENTRY;
        idx_d = 2'd0;
        cur_d = 4'd0;
        match_d = 1'b1;
      end
      ENTRY: if (p_clr) begin
        idx_d = 2'd0;
        cur_d = 4'd0;
        match_d = 1'b1;
      end else if (p_next) begin
        // ~idx selects nibble 3-idx, so [15:12] is compared first
        match_d = match & (cur_digit == CODE[{~idx, 2'b00} +: 4]);
        if (idx == 2'd3) begin
          state_d = match_d ? RES_OK : RES_ERR;
          timer_d = RESULT_CYCLES - 24'd1;
          fail_d = match_d ? 2'd0 : (fail_cnt == 2'd3 ? 2'd3 : fail_cnt + 2'd1);
        end else begin
          idx_d = idx + 2'd1;
          cur_d = 4'd0;
        end
      end else if (p_inc) cur_d = cur_digit == 4'd9 ? 4'd0 : cur_digit + 4'd1;
      RES_OK: if (timer == 24'd0) state_d = IDLE; else timer_d = timer - 24'd1;
      RES_ERR: if (timer == 24'd0) begin
        state_d = fail_cnt >= MAX_FAIL ? LOCKOUT : IDLE;
        timer_d = LOCK_CYCLES - 24'd1;
      end else timer_d = timer - 24'd1;
      LOCKOUT: if (timer == 24'd0) begin
        state_d = IDLE;
        fail_d = 2'd0;
      end else timer_d = timer - 24'd1;
      default: state_d = IDLE;
    endcase
  end
`ifdef CODE_ENTRY_BLINK_EN
  logic [23:0] bcnt;
  logic show, restart, wrap;
  // phase restarts on every state change so each result opens with its code visible
  assign restart = state_d != state;
  assign wrap = bcnt == BLINK_CYCLES - 24'd1;
  assign show_d = restart ? 1'b1 : wrap ? ~show : show;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
      show <= 1'b0;
    end else begin
      bcnt <= (restart | wrap) ? 24'd0 : bcnt + 24'd1;
      show <= show_d;
    end
  end
`else
  assign show_d = 1'b1;
`endif
  assign value_d = state_d == ENTRY ? cur_d :
                   state_d == IDLE || !show_d ? 4'd12 :
                   state_d == RES_OK ? 4'd10 : 4'd11;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cur_digit <= '0;
      match <= 1'b1;
      fail_cnt <= '0;
      timer <= '0;
      value <= 4'd12;
      digit_idx <= '0;
      unlocked <= 1'b0;
      locked <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      cur_digit <= cur_d;
      match <= match_d;
      fail_cnt <= fail_d;
      timer <= timer_d;
      value <= value_d;
      digit_idx <= state_d == ENTRY ? idx_d : 2'd0;
      unlocked <= state_d == RES_OK;
      locked <= state_d == LOCKOUT;
    end
  end
endmodule

// File: tb/tb_code_entry_ctrl.sv
// tb_code_entry_ctrl: randomized and directed checks of code_entry_ctrl against a digit-queue reference model
module tb_code_entry_ctrl;
  localparam logic [15:0] CODE = 16'h1234;
  localparam int R = 8;
  localparam int L = 16;
  localparam int B = 2;
  logic clk = 0, rst_n = 0, btn_inc = 0, btn_next = 0, btn_clear = 0;
  logic [3:0] value;
  logic [1:0] digit_idx;
  logic unlocked, locked;
  int tests = 0, fails = 0;
  bit m_entry;
  int m_dig[$];
  int m_cur, m_fails;
  code_entry_ctrl #(.CODE(CODE), .RESULT_CYCLES(24'd8), .LOCK_CYCLES(24'd16),
                    .MAX_FAIL(2'd3), .BLINK_CYCLES(24'd2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_next(btn_next), .btn_clear(btn_clear),
    .value(value), .digit_idx(digit_idx), .unlocked(unlocked), .locked(locked));
  always #5 clk = ~clk;
  function automatic logic [7:0] got();
    return {value, digit_idx, unlocked, locked};
  endfunction
  function automatic int code_digit(input int i);
    int c = CODE;
    return (c >> (12 - 4 * i)) & 15;
  endfunction
  function automatic int shown(input int code, input int i);
`ifdef CODE_ENTRY_BLINK_EN
    return ((i / B) % 2) != 0 ? 12 : code;
`else
    return code + 0 * i;
`endif
  endfunction
  function automatic logic [7:0] exp_out();
    return m_entry ? {4'(m_cur), 2'(m_dig.size()), 2'b00} : 8'hC0;
  endfunction
  function automatic void model_reset();
    m_entry = 0;
    m_dig.delete();
    m_cur = 0;
    m_fails = 0;
  endfunction
  // b = {clear, next, inc}; returns 0 none, 1 correct code, 2 wrong code
  function automatic int model_press(input logic [2:0] b);
    if (!m_entry) begin
      if (!b[2] && (b[0] || b[1])) begin
        m_entry = 1;
        m_dig.delete();
        m_cur = 0;
      end
      return 0;
    end
    if (b[2]) begin
      m_dig.delete();
      m_cur = 0;
      return 0;
    end
    if (b[1]) begin
      m_dig.push_back(m_cur);
      m_cur = 0;
      if (m_dig.size() == 4) begin
        bit ok = 1;
        for (int i = 0; i < 4; i++) if (m_dig[i] != code_digit(i)) ok = 0;
        m_entry = 0;
        return ok ? 1 : 2;
      end
      return 0;
    end
    if (b[0]) m_cur = (m_cur + 1) % 10;
    return 0;
  endfunction
  // ends on the third falling edge after the press started, when its effect is visible
  task automatic press(input logic [2:0] b, input int hold, output int res);
    @(negedge clk);
    {btn_clear, btn_next, btn_inc} = b;
    repeat (hold) @(negedge clk);
    {btn_clear, btn_next, btn_inc} = 3'b000;
    repeat (3 - hold) @(negedge clk);
    res = model_press(b);
  endtask
  task automatic step(input logic [2:0] b, input int hold);
    int res;
    press(b, hold, res);
    if (res == 0) begin
      tests++;
      if (got() !== exp_out()) begin
        fails++;
        $display("FAIL step b=%b: got %h required %h", b, got(), exp_out());
      end
      repeat (3) @(negedge clk);
    end else begin
      int v = res == 1 ? 10 : 11;
      for (int i = 0; i < R; i++) begin
        if (i == 2) {btn_clear, btn_next, btn_inc} = 3'b111;
        if (i == 3) {btn_clear, btn_next, btn_inc} = 3'b000;
        tests++;
        if (got() !== {4'(shown(v, i)), 2'd0, res == 1, 1'b0}) begin
          fails++;
          $display("FAIL result cyc %0d: got %h required %h", i, got(), {4'(shown(v, i)), 2'd0, res == 1, 1'b0});
        end
        @(negedge clk);
      end
      m_fails = res == 1 ? 0 : (m_fails < 3 ? m_fails + 1 : 3);
      if (m_fails >= 3) begin
        for (int i = 0; i < L; i++) begin
          if (i == 4) {btn_clear, btn_next, btn_inc} = 3'b111;
          if (i == 6) {btn_clear, btn_next, btn_inc} = 3'b000;
          tests++;
          if (got() !== {4'(shown(11, i)), 4'b0001}) begin
            fails++;
            $display("FAIL lockout cyc %0d: got %h required %h", i, got(), {4'(shown(11, i)), 4'b0001});
          end
          @(negedge clk);
        end
        m_fails = 0;
      end
      tests++;
      if (got() !== 8'hC0) begin
        fails++;
        $display("FAIL after result: got %h required c0", got());
      end
      repeat (2) @(negedge clk);
    end
  endtask
  task automatic enter_code(input int a, input int b, input int c, input int d);
    int ds[4] = '{a, b, c, d};
    if (!m_entry) step(3'b010, 1);
    for (int k = 0; k < 4; k++) begin
      repeat (ds[k]) step(3'b001, $urandom_range(1, 3));
      step(3'b010, $urandom_range(1, 3));
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    {btn_clear, btn_next, btn_inc} = 3'b000;
    #1;
    tests++;
    if (got() !== 8'hC0) begin
      fails++;
      $display("FAIL reset async: got %h required c0", got());
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    @(negedge clk);
    tests++;
    if (got() !== 8'hC0) begin
      fails++;
      $display("FAIL reset idle: got %h required c0", got());
    end
  endtask
  task automatic test_reset();
    do_reset();
    step(3'b100, 1);
  endtask
  task automatic test_correct();
    do_reset();
    enter_code(1, 2, 3, 4);
  endtask
  task automatic test_wrong();
    do_reset();
    enter_code(1, 2, 3, 5);
    enter_code(0, 2, 3, 4);
  endtask
  task automatic test_inc();
    int e;
    do_reset();
    step(3'b010, 1);
    repeat (10) step(3'b001, 1);
    @(negedge clk);
    btn_inc = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      e = i >= 3 ? (m_cur + 1) % 10 : m_cur;
      tests++;
      if (value !== 4'(e)) begin
        fails++;
        $display("FAIL inc hold cyc %0d: got %0d required %0d", i, value, e);
      end
    end
    btn_inc = 0;
    repeat (3) @(negedge clk);
    void'(model_press(3'b001));
    step(3'b001, 2);
  endtask
  task automatic test_lockout();
    do_reset();
    enter_code(4, 3, 2, 1);
    enter_code(1, 2, 3, 0);
    enter_code(9, 9, 9, 9);
    enter_code(1, 2, 3, 4);
  endtask
  task automatic test_priority();
    do_reset();
    step(3'b010, 1);
    repeat (5) step(3'b001, 1);
    step(3'b010, 1);
    repeat (6) step(3'b001, 1);
    step(3'b010, 1);
    step(3'b001, 1);
    step(3'b110, 1);
    enter_code(1, 2, 3, 4);
    step(3'b010, 1);
    step(3'b001, 1);
    step(3'b011, 1);
    step(3'b101, 1);
  endtask
  task automatic test_random();
    int r;
    logic [2:0] b;
    do_reset();
    repeat (200) begin
      r = $urandom_range(0, 99);
      b = r < 45 ? 3'b001 : r < 80 ? 3'b010 : r < 85 ? 3'b100 : 3'($urandom_range(1, 7));
      step(b, $urandom_range(1, 3));
    end
  endtask
  task automatic test_async_reset();
    int res;
    do_reset();
    enter_code(0, 0, 0, 0);
    enter_code(5, 5, 5, 5);
    step(3'b010, 1);
    for (int k = 1; k <= 3; k++) begin
      repeat (k) step(3'b001, 1);
      step(3'b010, 1);
    end
    step(3'b001, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    tests++;
    if (got() !== 8'hC0) begin
      fails++;
      $display("FAIL reset mid entry: got %h required c0", got());
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    enter_code(7, 7, 7, 7);
    step(3'b010, 1);
    for (int k = 1; k <= 3; k++) begin
      repeat (k) step(3'b001, 1);
      step(3'b010, 1);
    end
    repeat (4) step(3'b001, 1);
    press(3'b010, 1, res);
    repeat (3) @(negedge clk);
    tests++;
    if ({res[1:0], unlocked} !== 3'b011) begin
      fails++;
      $display("FAIL mid ok: got res %0d unlocked %b required 1 1", res, unlocked);
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if (got() !== 8'hC0) begin
      fails++;
      $display("FAIL reset mid ok: got %h required c0", got());
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    step(3'b010, 1);
  endtask
  initial begin
    model_reset();
    test_reset();
    test_correct();
    test_wrong();
    test_inc();
    test_lockout();
    test_priority();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
